// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the write-back stage:
//   - RESULT_SRC_* result-select encodings (result_src_e)
//   - funct3 load-type constants
//   - write-back FSM state enum (wb_state_e)
//   - load_size_bytes(): access size in bytes of a load funct3
// ---------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        RESULT_SRC_ALU    = 2'd0,
        RESULT_SRC_MEMORY = 2'd1,
        RESULT_SRC_PC_P4  = 2'd2
    } result_src_e;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_HI = 1'b1
    } wb_state_e;

    // Size 0 marks an illegal load type: it never crosses a beat and reads as 0.
    function automatic logic [3:0] load_size_bytes(input logic [2:0] funct3,
                                                   input logic       rv64);
        case (funct3)
            FUNCT3_LB, FUNCT3_LBU: load_size_bytes = 4'd1;
            FUNCT3_LH, FUNCT3_LHU: load_size_bytes = 4'd2;
            FUNCT3_LW:             load_size_bytes = 4'd4;
            FUNCT3_LWU:            load_size_bytes = rv64 ? 4'd4 : 4'd0;
            FUNCT3_LD:             load_size_bytes = rv64 ? 4'd8 : 4'd0;
            default:               load_size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/core_write_back_if.sv
// ---------------------------------------------------------------------------
// core_write_back_if
// Bundle of all non-clock/reset signals of core_write_back.
//   i_valid/o_ready         upstream request handshake
//   i_data, i_alu_result,   request payload (load beat, ALU result / address,
//   i_pc_p4, i_funct3,      PC+4 bits [XLEN-1:2], load type, result select,
//   i_res_src, i_rd         destination register)
//   o_hi_req/i_hi_valid/    next-beat fetch for loads crossing a beat
//   i_hi_data
//   o_valid/i_ready,        downstream result handshake and payload
//   o_data, o_rd, o_misaligned
// Modports: master = upstream/downstream environment, slave = write-back stage.
// ---------------------------------------------------------------------------
interface core_write_back_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            i_valid;
    logic            o_ready;
    logic [XLEN-1:0] i_data;
    logic [XLEN-1:0] i_alu_result;
    logic [XLEN-3:0] i_pc_p4;
    logic [2:0]      i_funct3;
    logic [1:0]      i_res_src;
    logic [RD_W-1:0] i_rd;
    logic            o_hi_req;
    logic            i_hi_valid;
    logic [XLEN-1:0] i_hi_data;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_data;
    logic [RD_W-1:0] o_rd;
    logic            o_misaligned;

    modport master (
        output i_valid, i_data, i_alu_result, i_pc_p4, i_funct3, i_res_src, i_rd,
               i_hi_valid, i_hi_data, i_ready,
        input  o_ready, o_hi_req, o_valid, o_data, o_rd, o_misaligned
    );

    modport slave (
        input  i_valid, i_data, i_alu_result, i_pc_p4, i_funct3, i_res_src, i_rd,
               i_hi_valid, i_hi_data, i_ready,
        output o_ready, o_hi_req, o_valid, o_data, o_rd, o_misaligned
    );
endinterface

// File: rtl/core_load_align.sv
// ---------------------------------------------------------------------------
// core_load_align
// Combinational load extraction: shifts a two-beat window right by the byte
// offset and sign/zero-extends the selected byte/half/word(/double) to XLEN.
//   i_window  {high beat, low beat}; high beat is zero for single-beat loads
//   i_offset  byte offset of the load inside the low beat
//   i_funct3  load type
//   o_result  extended load value, 0 for an unsupported funct3
// ---------------------------------------------------------------------------
module core_load_align
    import core_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] i_window,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [2:0]        i_funct3,
    output logic [XLEN-1:0]   o_result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted  = XLEN'(i_window >> {i_offset, 3'b000});
        o_result = '0;
        case (i_funct3)
            FUNCT3_LB:  o_result = XLEN'($signed(shifted[7:0]));
            FUNCT3_LH:  o_result = XLEN'($signed(shifted[15:0]));
            FUNCT3_LW:  o_result = XLEN'($signed(shifted[31:0]));
            FUNCT3_LBU: o_result = XLEN'(shifted[7:0]);
            FUNCT3_LHU: o_result = XLEN'(shifted[15:0]);
            // Doubleword and unsigned word only exist on a 64-bit datapath.
            FUNCT3_LD:  if (XLEN == 64) o_result = shifted;
            FUNCT3_LWU: if (XLEN == 64) o_result = XLEN'(shifted[31:0]);
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/core_write_back.sv
// ---------------------------------------------------------------------------
// core_write_back
// Write-back stage: selects ALU result, extracted load or PC+4, and registers
// it towards the register file with a valid/ready handshake.
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   wb         core_write_back_if.slave (request, next-beat and result ports)
// Build option CORE_MISALIGNED_LOAD_EN: when defined, a load crossing the beat
// boundary waits (WAIT_HI) for the next beat and merges both; when undefined
// such a load completes at once with o_data 0 and o_misaligned 1.
// ---------------------------------------------------------------------------
module core_write_back
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input logic              i_clk,
    input logic              i_reset_n,
    core_write_back_if.slave wb
);

    localparam int OFF_W      = $clog2(XLEN / 8);
    localparam int BEAT_BYTES = XLEN / 8;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              misaligned_q, misaligned_d;

    logic              accept;
    logic              crossing;
    logic [OFF_W-1:0]  req_offset;
    logic [3:0]        req_size;
    logic [XLEN-1:0]   req_result;
    logic [2*XLEN-1:0] align_window;
    logic [OFF_W-1:0]  align_offset;
    logic [2:0]        align_funct3;
    logic [XLEN-1:0]   align_result;

`ifdef CORE_MISALIGNED_LOAD_EN
    wb_state_e         state_q, state_d;
    logic              hi_req_q, hi_req_d;
    logic [XLEN-1:0]   lo_beat_q, lo_beat_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [RD_W-1:0]   pend_rd_q, pend_rd_d;

    assign wb.o_ready  = (state_q == IDLE) && (!valid_q || wb.i_ready);
    assign wb.o_hi_req = hi_req_q;

    // While waiting, the aligner works on the captured low beat and the
    // incoming high beat so the merged result is ready on i_hi_valid.
    always_comb begin
        if (state_q == WAIT_HI) begin
            align_window = {wb.i_hi_data, lo_beat_q};
            align_offset = offset_q;
            align_funct3 = funct3_q;
        end else begin
            align_window = {{XLEN{1'b0}}, wb.i_data};
            align_offset = req_offset;
            align_funct3 = wb.i_funct3;
        end
    end
`else
    logic unused_hi_beat;

    assign unused_hi_beat = ^{wb.i_hi_valid, wb.i_hi_data};
    assign wb.o_ready     = !valid_q || wb.i_ready;
    assign wb.o_hi_req    = 1'b0;
    assign align_window   = {{XLEN{1'b0}}, wb.i_data};
    assign align_offset   = req_offset;
    assign align_funct3   = wb.i_funct3;
`endif

    assign accept     = wb.i_valid && wb.o_ready;
    assign req_offset = wb.i_alu_result[OFF_W-1:0];
    assign req_size   = load_size_bytes(wb.i_funct3, XLEN == 64);
    // Only memory results can be misaligned; other sources ignore the address.
    assign crossing   = (wb.i_res_src == RESULT_SRC_MEMORY) &&
                        ((5'(req_offset) + 5'(req_size)) > 5'(BEAT_BYTES));

    core_load_align #(.XLEN(XLEN)) u_load_align (
        .i_window (align_window),
        .i_offset (align_offset),
        .i_funct3 (align_funct3),
        .o_result (align_result)
    );

    always_comb begin
        case (wb.i_res_src)
            RESULT_SRC_ALU:    req_result = wb.i_alu_result;
            RESULT_SRC_MEMORY: req_result = align_result;
            RESULT_SRC_PC_P4:  req_result = {wb.i_pc_p4, 2'b00};
            default:           req_result = '0;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        rd_d         = rd_q;
        misaligned_d = misaligned_q;
`ifdef CORE_MISALIGNED_LOAD_EN
        state_d      = state_q;
        hi_req_d     = hi_req_q;
        lo_beat_d    = lo_beat_q;
        offset_d     = offset_q;
        funct3_d     = funct3_q;
        pend_rd_d    = pend_rd_q;
`endif
        if (valid_q && wb.i_ready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (crossing) begin
`ifdef CORE_MISALIGNED_LOAD_EN
                state_d   = WAIT_HI;
                hi_req_d  = 1'b1;
                lo_beat_d = wb.i_data;
                offset_d  = req_offset;
                funct3_d  = wb.i_funct3;
                pend_rd_d = wb.i_rd;
`else
                valid_d      = 1'b1;
                data_d       = '0;
                misaligned_d = 1'b1;
                rd_d         = wb.i_rd;
`endif
            end else begin
                valid_d      = 1'b1;
                data_d       = req_result;
                misaligned_d = 1'b0;
                rd_d         = wb.i_rd;
            end
        end
`ifdef CORE_MISALIGNED_LOAD_EN
        // o_valid is always low in WAIT_HI, so the merged result never
        // overwrites an unconsumed output.
        if ((state_q == WAIT_HI) && wb.i_hi_valid) begin
            state_d      = IDLE;
            hi_req_d     = 1'b0;
            valid_d      = 1'b1;
            data_d       = align_result;
            misaligned_d = 1'b0;
            rd_d         = pend_rd_q;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q      <= 1'b0;
            data_q       <= '0;
            rd_q         <= '0;
            misaligned_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            rd_q         <= rd_d;
            misaligned_q <= misaligned_d;
        end
    end

`ifdef CORE_MISALIGNED_LOAD_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            hi_req_q  <= 1'b0;
            lo_beat_q <= '0;
            offset_q  <= '0;
            funct3_q  <= '0;
            pend_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_req_q  <= hi_req_d;
            lo_beat_q <= lo_beat_d;
            offset_q  <= offset_d;
            funct3_q  <= funct3_d;
            pend_rd_q <= pend_rd_d;
        end
    end
`endif

    assign wb.o_valid      = valid_q;
    assign wb.o_data       = data_q;
    assign wb.o_rd         = rd_q;
    assign wb.o_misaligned = misaligned_q;

endmodule

// File: tb/tb_core_write_back.sv
// ---------------------------------------------------------------------------
// tb_core_write_back
// Directed bench for core_write_back with a 32-bit and a 64-bit instance.
// Expectations for beat-crossing loads follow CORE_MISALIGNED_LOAD_EN.
// ---------------------------------------------------------------------------
module tb_core_write_back;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    core_write_back_if #(.XLEN(32), .RD_W(5)) bus32 ();
    core_write_back_if #(.XLEN(64), .RD_W(5)) bus64 ();

    core_write_back #(.XLEN(32), .RD_W(5)) dut32 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .wb        (bus32)
    );

    core_write_back #(.XLEN(64), .RD_W(5)) dut64 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .wb        (bus64)
    );

    typedef struct {
        logic [1:0]  res_src;
        logic [2:0]  funct3;
        logic [31:0] alu;
        logic [31:0] data;
        logic [29:0] pc_p4;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] res_src,
                                 input logic [2:0] funct3, input logic [31:0] alu,
                                 input logic [31:0] data, input logic [29:0] pc_p4,
                                 input logic [4:0] rd);
        bus32.i_valid      = valid;
        bus32.i_res_src    = res_src;
        bus32.i_funct3     = funct3;
        bus32.i_alu_result = alu;
        bus32.i_data       = data;
        bus32.i_pc_p4      = pc_p4;
        bus32.i_rd         = rd;
    endtask

    task automatic checkResult32(input string tag, input logic [31:0] exp_data,
                                 input logic [4:0] exp_rd, input logic exp_mis);
        checkOutput({tag, " o_valid"}, 64'(bus32.o_valid), 64'd1);
        checkOutput({tag, " o_data"}, 64'(bus32.o_data), 64'(exp_data));
        checkOutput({tag, " o_rd"}, 64'(bus32.o_rd), 64'(exp_rd));
        checkOutput({tag, " o_misaligned"}, 64'(bus32.o_misaligned), 64'(exp_mis));
        checkOutput({tag, " o_hi_req"}, 64'(bus32.o_hi_req), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // {res_src, funct3, alu/addr, beat, pc_p4[31:2], rd, expected data, expected misaligned}
        vecs[0] = '{RESULT_SRC_MEMORY, FUNCT3_LB,  32'h0000_1003, 32'h8011_2233, 30'h0,  5'd1,  32'hFFFF_FF80, 1'b0};
        vecs[1] = '{RESULT_SRC_MEMORY, FUNCT3_LHU, 32'h0000_2002, 32'hBEEF_0000, 30'h0,  5'd2,  32'h0000_BEEF, 1'b0};
        // PC+4 = 0x100 is carried as bits [31:2] = 0x40; the odd address must not count
        vecs[2] = '{RESULT_SRC_PC_P4,  FUNCT3_LW,  32'h0000_0003, 32'hFFFF_FFFF, 30'h40, 5'd3,  32'h0000_0100, 1'b0};
        vecs[3] = '{RESULT_SRC_ALU,    FUNCT3_LW,  32'h1234_5677, 32'h0000_0000, 30'h0,  5'd4,  32'h1234_5677, 1'b0};
        vecs[4] = '{RESULT_SRC_MEMORY, FUNCT3_LH,  32'h0000_0002, 32'h8001_0000, 30'h0,  5'd5,  32'hFFFF_8001, 1'b0};
        vecs[5] = '{RESULT_SRC_MEMORY, FUNCT3_LW,  32'h0000_0100, 32'hDEAD_BEEF, 30'h0,  5'd6,  32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{RESULT_SRC_MEMORY, FUNCT3_LBU, 32'h0000_0001, 32'h0000_F000, 30'h0,  5'd7,  32'h0000_00F0, 1'b0};
        vecs[7] = '{2'd3,              FUNCT3_LW,  32'h1111_1111, 32'h2222_2222, 30'h3,  5'd8,  32'h0000_0000, 1'b0};
        vecs[8] = '{RESULT_SRC_MEMORY, FUNCT3_LD,  32'h0000_0000, 32'h3333_3333, 30'h0,  5'd9,  32'h0000_0000, 1'b0};
        vecs[9] = '{RESULT_SRC_MEMORY, FUNCT3_LBU, 32'h0000_0003, 32'h7F00_0000, 30'h0,  5'd10, 32'h0000_007F, 1'b0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 30'd0, 5'd0);
        bus32.i_hi_valid = 1'b0;
        bus32.i_hi_data  = '0;
        bus32.i_ready    = 1'b1;
        bus64.i_valid      = 1'b0;
        bus64.i_res_src    = '0;
        bus64.i_funct3     = '0;
        bus64.i_alu_result = '0;
        bus64.i_data       = '0;
        bus64.i_pc_p4      = '0;
        bus64.i_rd         = '0;
        bus64.i_hi_valid   = 1'b0;
        bus64.i_hi_data    = '0;
        bus64.i_ready      = 1'b1;

        #12;
        checkOutput("reset32 o_valid", 64'(bus32.o_valid), 64'd0);
        checkOutput("reset32 o_data", 64'(bus32.o_data), 64'd0);
        checkOutput("reset32 o_rd", 64'(bus32.o_rd), 64'd0);
        checkOutput("reset32 o_misaligned", 64'(bus32.o_misaligned), 64'd0);
        checkOutput("reset32 o_hi_req", 64'(bus32.o_hi_req), 64'd0);
        checkOutput("reset64 o_valid", 64'(bus64.o_valid), 64'd0);
        checkOutput("reset64 o_data", bus64.o_data, 64'd0);
        checkOutput("reset64 o_hi_req", 64'(bus64.o_hi_req), 64'd0);
        rst_n = 1'b1;
        waitCycle();

        // Single-beat vectors, back to back with i_ready high
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b1, vecs[i].res_src, vecs[i].funct3, vecs[i].alu,
                          vecs[i].data, vecs[i].pc_p4, vecs[i].rd);
            #1;
            checkOutput($sformatf("vec%0d o_ready", i), 64'(bus32.o_ready), 64'd1);
            waitCycle();
            bus32.i_valid = 1'b0;
            checkResult32($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].rd, vecs[i].exp_mis);
        end
        waitCycle();
        checkOutput("drain o_valid", 64'(bus32.o_valid), 64'd0);

        // i_hi_valid in IDLE must not produce a result
        bus32.i_hi_valid = 1'b1;
        bus32.i_hi_data  = 32'h5A5A_5A5A;
        waitCycle();
        bus32.i_hi_valid = 1'b0;
        checkOutput("idle hi o_valid", 64'(bus32.o_valid), 64'd0);
        checkOutput("idle hi o_hi_req", 64'(bus32.o_hi_req), 64'd0);

        // LW crossing the beat: offset 3, low beat 0xAA000000, high beat 3 cycles later
        applyStimulus(1'b1, RESULT_SRC_MEMORY, FUNCT3_LW, 32'h0000_1003, 32'hAA00_0000, 30'd0, 5'd9);
        waitCycle();
`ifdef CORE_MISALIGNED_LOAD_EN
        // A new request during WAIT_HI must be ignored
        applyStimulus(1'b1, RESULT_SRC_ALU, FUNCT3_LW, 32'h5555_5555, 32'd0, 30'd0, 5'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) waitCycle();
            checkOutput($sformatf("wait%0d o_hi_req", k), 64'(bus32.o_hi_req), 64'd1);
            checkOutput($sformatf("wait%0d o_valid", k), 64'(bus32.o_valid), 64'd0);
            checkOutput($sformatf("wait%0d o_ready", k), 64'(bus32.o_ready), 64'd0);
        end
        bus32.i_valid    = 1'b0;
        bus32.i_hi_valid = 1'b1;
        bus32.i_hi_data  = 32'h00CC_BBDD;
        waitCycle();
        bus32.i_hi_valid = 1'b0;
        checkResult32("merge", 32'hCCBB_DDAA, 5'd9, 1'b0);
        waitCycle();
        checkOutput("merge drain o_valid", 64'(bus32.o_valid), 64'd0);
`else
        bus32.i_valid = 1'b0;
        checkResult32("crossing", 32'h0000_0000, 5'd9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            waitCycle();
            checkOutput($sformatf("crossing%0d o_hi_req", k), 64'(bus32.o_hi_req), 64'd0);
            checkOutput($sformatf("crossing%0d o_valid", k), 64'(bus32.o_valid), 64'd0);
        end
`endif

        // Reset asserted in the cycle after a crossing load is accepted
        applyStimulus(1'b1, RESULT_SRC_MEMORY, FUNCT3_LW, 32'h0000_2003, 32'hAA00_0000, 30'd0, 5'd12);
        waitCycle();
        bus32.i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset o_valid", 64'(bus32.o_valid), 64'd0);
        checkOutput("midreset o_hi_req", 64'(bus32.o_hi_req), 64'd0);
        checkOutput("midreset o_misaligned", 64'(bus32.o_misaligned), 64'd0);
        checkOutput("midreset o_data", 64'(bus32.o_data), 64'd0);
        #2;
        rst_n = 1'b1;
        waitCycle();
        applyStimulus(1'b1, RESULT_SRC_MEMORY, FUNCT3_LW, 32'h0000_0020, 32'h1122_3344, 30'd0, 5'd3);
        #1;
        checkOutput("postreset o_ready", 64'(bus32.o_ready), 64'd1);
        waitCycle();
        bus32.i_valid = 1'b0;
        checkResult32("postreset", 32'h1122_3344, 5'd3, 1'b0);

        // 64-bit LWU at offset 4 with the consumer stalled for 4 cycles
        bus64.i_valid      = 1'b1;
        bus64.i_res_src    = RESULT_SRC_MEMORY;
        bus64.i_funct3     = FUNCT3_LWU;
        bus64.i_alu_result = 64'h0000_0000_0000_3004;
        bus64.i_data       = 64'hFFFF_FFFF_0000_0000;
        bus64.i_rd         = 5'd17;
        bus64.i_ready      = 1'b0;
        #1;
        checkOutput("lwu o_ready", 64'(bus64.o_ready), 64'd1);
        waitCycle();
        // A competing request must stay blocked while the output is held
        bus64.i_res_src    = RESULT_SRC_ALU;
        bus64.i_alu_result = 64'h0000_0000_0000_ABCD;
        bus64.i_rd         = 5'd2;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("hold%0d o_valid", k), 64'(bus64.o_valid), 64'd1);
            checkOutput($sformatf("hold%0d o_data", k), bus64.o_data, 64'h0000_0000_FFFF_FFFF);
            checkOutput($sformatf("hold%0d o_rd", k), 64'(bus64.o_rd), 64'd17);
            checkOutput($sformatf("hold%0d o_ready", k), 64'(bus64.o_ready), 64'd0);
            waitCycle();
        end
        bus64.i_valid = 1'b0;
        bus64.i_ready = 1'b1;
        #1;
        checkOutput("release o_ready", 64'(bus64.o_ready), 64'd1);
        waitCycle();
        checkOutput("release o_valid", 64'(bus64.o_valid), 64'd0);

        // 64-bit LD and sign-extending LW at offset 4
        for (int k = 0; k < 2; k++) begin
            bus64.i_valid      = 1'b1;
            bus64.i_res_src    = RESULT_SRC_MEMORY;
            bus64.i_funct3     = (k == 0) ? FUNCT3_LD : FUNCT3_LW;
            bus64.i_alu_result = (k == 0) ? 64'h0000_0000_0000_0008 : 64'h0000_0000_0000_0004;
            bus64.i_data       = (k == 0) ? 64'h0123_4567_89AB_CDEF : 64'h8000_0000_0000_0000;
            bus64.i_rd         = 5'(20 + k);
            waitCycle();
            bus64.i_valid = 1'b0;
            checkOutput($sformatf("rv64_%0d o_valid", k), 64'(bus64.o_valid), 64'd1);
            checkOutput($sformatf("rv64_%0d o_data", k), bus64.o_data,
                        (k == 0) ? 64'h0123_4567_89AB_CDEF : 64'hFFFF_FFFF_8000_0000);
            checkOutput($sformatf("rv64_%0d o_misaligned", k), 64'(bus64.o_misaligned), 64'd0);
        end
        waitCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_write_back.md
CORE_WRITE_BACK -- requirements
Module: core_write_back

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RD_W, default 5, destination register index width.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  upstream writeback request present.
REQ-006 SHALL have port o_ready  output  1  request accepted this cycle when high with i_valid.
REQ-007 SHALL have port i_data  input  XLEN  memory beat containing the load start address.
REQ-008 SHALL have port i_alu_result  input  XLEN  ALU result / load byte address.
REQ-009 SHALL have port i_pc_p4  input  XLEN-2  PC+4 bits [XLEN-1:2].
REQ-010 SHALL have ports i_funct3  input  3  load type; i_res_src  input  2  result select; i_rd  input  RD_W  destination.
REQ-011 SHALL have ports o_hi_req  output  1  next-beat request; i_hi_valid  input  1  next beat present; i_hi_data  input  XLEN  next aligned beat.
REQ-012 SHALL have ports o_valid  output  1; i_ready  input  1; o_data  output  XLEN; o_rd  output  RD_W; o_misaligned  output  1 (load-misaligned flag).

Function
REQ-013 SHALL select result: RESULT_SRC_ALU -> i_alu_result; RESULT_SRC_MEMORY -> extracted load; RESULT_SRC_PC_P4 -> {i_pc_p4, 2'b00}; other -> 0.
REQ-014 SHALL extract loads by funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU sign/zero-extended to XLEN; XLEN=64 adds 011 LD, 110 LWU; any other funct3 -> 0.
REQ-015 SHALL use address low bits log2(XLEN/8) as byte offset into the beat.
REQ-016 SHALL assert o_ready = (state==IDLE) && (!o_valid || i_ready).
REQ-017 SHALL register all outputs; aligned accepted request -> o_valid high next cycle (latency 1).
REQ-018 SHALL hold o_valid, o_data, o_rd, o_misaligned stable while o_valid && !i_ready.
REQ-019 SHALL implement FSM IDLE, WAIT_HI: IDLE->WAIT_HI on accepted memory load whose offset+size exceeds XLEN/8 bytes (with REQ-027); WAIT_HI->IDLE on i_hi_valid.
REQ-020 SHALL in WAIT_HI drive o_hi_req high, hold captured low beat, offset, funct3, rd.
REQ-021 SHALL on i_hi_valid merge {i_hi_data, low beat} shifted right by offset*8, then extend per funct3; o_valid next cycle.
REQ-022 SHALL ignore i_hi_valid in IDLE and i_valid in WAIT_HI.
REQ-023 SHALL never treat non-memory res_src as misaligned, regardless of address.

Reset
REQ-024 SHALL on i_reset_n low asynchronously force state IDLE, o_valid 0, o_hi_req 0, o_misaligned 0, o_data 0, o_rd 0.
REQ-025 SHALL discard any pending WAIT_HI transaction on reset; first post-reset request handled normally.

Configuration
REQ-026 Macro CORE_MISALIGNED_LOAD_EN SHALL gate two-beat merging.
REQ-027 With macro defined: REQ-019..021 active, o_misaligned always 0.
REQ-028 Without: no WAIT_HI state, o_hi_req tied 0; a crossing load completes in 1 cycle with o_data 0, o_misaligned 1.

Structure
REQ-029 RESULT_SRC_* encodings, funct3 load constants, FSM state enum SHALL live in shared package core_pkg.
REQ-030 Byte/half/word extraction and extension SHALL be sub-module core_load_align (combinational, XLEN-parametrised), instanced once.

Verification
REQ-031 XLEN=32, LB, addr 0x...3, i_data 0x80112233 -> o_data 0xFFFFFF80, o_valid next cycle.
REQ-032 XLEN=32, LHU, addr 0x...2, i_data 0xBEEF0000 -> o_data 0x0000BEEF; res_src PC_P4, pc_p4 0x100 -> o_data 0x100.
REQ-033 Macro on, XLEN=32, LW addr 0x...3, low 0xAA000000, i_hi_data 0x00CCBBDD after 3-cycle delay -> o_hi_req high 3 cycles, o_data 0xCCBBDDAA, o_ready low throughout.
REQ-034 Macro off, same stimulus -> o_misaligned 1, o_data 0, o_hi_req never high.
REQ-035 XLEN=64, LWU addr 0x...4, i_data 0xFFFFFFFF_00000000 -> o_data 0x00000000_FFFFFFFF; i_ready low 4 cycles -> outputs held, o_ready low.
REQ-036 i_reset_n low mid-WAIT_HI -> o_valid/o_hi_req 0 immediately; next aligned LW returns correct data.
